arb_burst_requester: RTL
========================

Name: arb_burst_requester

Overview:
- Requester-side agent for the 4-channel round-robin arbiter wrapper.
- Accepts one burst-write command at a time from a local producer and raises its req line to the arbiter.
- While its grant bit is high, streams the burst beats onto the shared bus, then drops req so the arbiter can rotate.
- One instance per channel; the instance's req output drives req_1..req_4, and the arbiter's 4-bit grant is fed back to every instance.

Parameters:
- CH_ID, 0, index of this instance's bit in grant (0..3; CH_ID 0 pairs with req_1).
- DATA_W, 16, beat data width.
- ADDR_W, 12, bus word-address width.
- LEN_W, 4, burst-length field width; beats per burst = cmd_len+1 (1..2^LEN_W).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_addr  input  ADDR_W  burst base word address.
- cmd_len  input  LEN_W  beats minus one.
- wdata  input  DATA_W  beat data from producer.
- wvalid  input  1  wdata valid.
- wready  output  1  beat consumed this cycle.
- req  output  1  request to arbiter.
- grant  input  4  arbiter grant vector (one-hot or zero).
- bus_valid  output  1  beat presented on shared bus.
- bus_ready  input  1  shared bus accepts beat.
- bus_addr  output  ADDR_W  address of current beat.
- bus_data  output  DATA_W  data of current beat.
- bus_last  output  1  current beat is the final beat.
- done  output  1  one-cycle pulse when a burst completes.
- wait_cnt  output  8  saturating count of stalled cycles in the last/current burst.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State becomes IDLE; beat counter and wait_cnt clear to 0.
  - Outputs after the edge: req=0, done=0, bus_valid=0, wready=0, bus_last=0, cmd_ready=1, bus_addr=0.
  - Reset applies mid-burst too: the burst is abandoned, no done pulse, and remaining beats are never issued.
- Definitions:
  - g = grant[CH_ID]. All other grant bits are ignored.
  - A beat transfers when bus_valid & bus_ready.
  - Latched length L = cmd_len+1 beats. cnt counts 0..L-1.
- IDLE:
  - cmd_ready=1, req=0.
  - On cmd_valid: latch addr/len, clear cnt and wait_cnt, go to REQ.
  - Commands are accepted only in IDLE; cmd_ready=0 in every other state.
- REQ:
  - req=1 (registered, high from the first REQ cycle).
  - g=0: wait_cnt increments.
  - g=1: go to XFER. No beat transfers in the REQ cycle itself.
  - A grant seen while in IDLE or REL is ignored.
- XFER:
  - req stays 1.
  - Combinational outputs: bus_valid = g & wvalid; wready = g & wvalid & bus_ready; bus_data = wdata; bus_addr = base + cnt, modulo 2^ADDR_W (wraps past all-ones, e.g. base 0xFFE with L=4 gives FFE, FFF, 000, 001); bus_last = (cnt == L-1).
  - Each transfer increments cnt.
  - Any XFER cycle with g=0, or with g=1 and wvalid=0, increments wait_cnt.
  - wait_cnt saturates at 255.
  - A cycle with g=1, wvalid=1, bus_ready=0 is a bus stall: hold all outputs, do not count.
  - Grant revoked mid-burst (g falls): beats pause with bus_valid=0, req held, cnt preserved. Resume at the same address when g returns; the arbiter is never re-requested from scratch.
  - Transfer with bus_last=1: go to REL.
- REL (exactly 1 cycle):
  - req=0, done=1; then return to IDLE.
  - The mandatory low cycle on req lets the round-robin arbiter rotate.
  - A back-to-back command is therefore accepted at the earliest on the cycle after REL.
- Latency:
  - cmd accept edge to req high: 1 cycle.
  - g high (sampled in REQ) to first possible bus_valid: 1 cycle.
  - Final transfer to done: 1 cycle.
- wait_cnt holds its value from burst end until the next command is accepted.

Test Plan:
- Single burst, immediate grant: cmd_addr=0x010, cmd_len=3, wvalid always 1, bus_ready always 1, grant[CH_ID] asserted the cycle after req rises.
  - Expect bus_addr 0x010..0x013 on 4 consecutive cycles, bus_last only on 0x013.
  - Expect done pulse 1 cycle later, req low for exactly that cycle, wait_cnt=0.
- Delayed grant: grant held 0 for 5 cycles after req rises.
  - Expect no bus_valid during the wait, then 4 beats, final wait_cnt=5.
- Grant revoked mid-burst: cmd_len=7; grant drops for 3 cycles after beat 2 (address base+2).
  - Expect bus_valid=0 during those 3 cycles with req still 1.
  - Resume at base+3, all 8 beats in order, wait_cnt=3.
- Address wrap and bus stall: cmd_addr=0xFFE, cmd_len=3; bus_ready low for 2 cycles on beat 1.
  - Expect addresses FFE, FFF (held 3 cycles), 000, 001.
  - Expect wait_cnt=0, since bus stalls are not counted.
- Back-to-back commands and foreign grants: two cmds offered continuously; another channel's grant bit toggles throughout.
  - Expect foreign grants ignored and cmd_ready=0 until the cycle after REL.
  - Expect req low for exactly 1 cycle between the bursts.
- Reset mid-operation: rst_n low for 1 cycle during beat 2 of an 8-beat burst.
  - Expect req=0, bus_valid=0, cmd_ready=1, wait_cnt=0 after the edge, and no done pulse.
  - A new command then starts cleanly from its own base address.

Source files
------------

// File: rtl/arb_burst_requester.sv
// Requester-side agent for a 4-channel round-robin arbiter.
// Takes one burst-write command at a time, requests the shared bus and
// streams the beats while its grant bit is high. It then drops req for one
// cycle so that the arbiter can rotate to the next channel.
module arb_burst_requester #(
  parameter int CH_ID  = 0,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              req,
  input  logic [3:0]        grant,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              done,
  output logic [7:0]        wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic [7:0]        wait_q,  wait_d;

  // Only this channel's grant bit matters; the rest of the vector is
  // folded into a throw-away signal.
  logic g;
  logic unused_grant;
  assign g            = grant[CH_ID];
  assign unused_grant = ^grant;

  // Stall counter stops at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wait_cnt = wait_q;

  // Next-state and output decode; all outputs derive from registered state
  // plus the live handshake inputs during XFER.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    cmd_ready = 1'b0;
    req       = 1'b0;
    done      = 1'b0;
    bus_valid = 1'b0;
    wready    = 1'b0;
    bus_last  = 1'b0;
    bus_data  = wdata;
    bus_addr  = base_q + ADDR_W'(cnt_q);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          base_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          wait_d  = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (g) begin
          state_d = S_XFER;
        end else begin
          wait_d = sat_inc(wait_q);
        end
      end
      S_XFER: begin
        req       = 1'b1;
        bus_valid = g & wvalid;
        wready    = g & wvalid & bus_ready;
        bus_last  = (cnt_q == len_q);
        if (!g || !wvalid) begin
          // Lost grant or producer starved: counts as a wait cycle.
          wait_d = sat_inc(wait_q);
        end else if (bus_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) begin
            state_d = S_REL;
          end
        end
        // g & wvalid & !bus_ready is a bus stall: hold everything.
      end
      S_REL: begin
        // Single req-low cycle that lets the arbiter rotate.
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and burst context registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

endmodule
